// File: rtl/sprite_compositor.sv
// ============================================================================
// sprite_compositor : two-stage sprite/text/background pixel compositor with
//                     per-sprite synchronous ROM reads and collision flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_compositor #(
   parameter int NUM_SPRITES = 6,
   parameter int SPRITE_W    = 32,
   parameter int SPRITE_H    = 32,
   parameter int ROM_AW      = 7
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            pix_valid,
   input  logic [9:0]                      DrawX,
   input  logic [9:0]                      DrawY,
   input  logic                            frame_start,
   input  logic [10*NUM_SPRITES-1:0]       spr_x,
   input  logic [10*NUM_SPRITES-1:0]       spr_y,
   input  logic [ROM_AW*NUM_SPRITES-1:0]   spr_base,
   input  logic [24*NUM_SPRITES-1:0]       spr_rgb,
   input  logic [NUM_SPRITES-1:0]          spr_en,
   input  logic [NUM_SPRITES-1:0]          spr_flip,
   input  logic [7:0]                      bg_r,
   input  logic [7:0]                      bg_g,
   input  logic [7:0]                      bg_b,
   input  logic                            draw_text,
   input  logic                            text_pixel,
   output logic [ROM_AW*NUM_SPRITES-1:0]   rom_addr,
   input  logic [SPRITE_W*NUM_SPRITES-1:0] rom_data,
   output logic [7:0]                      VGA_R,
   output logic [7:0]                      VGA_G,
   output logic [7:0]                      VGA_B,
   output logic                            out_valid,
   output logic [NUM_SPRITES-1:0]          collision,
   output logic [NUM_SPRITES-1:0]          collision_last
);

   localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

   logic [NUM_SPRITES-1:0]      w_hit;
   logic [CW-1:0]               w_col [NUM_SPRITES];

   logic [NUM_SPRITES-1:0]      r_hit;
   logic [CW-1:0]               r_col [NUM_SPRITES];
   logic [7:0]                  r_bg_r, r_bg_g, r_bg_b;
   logic                        r_text;
   logic                        r_v1;
   logic [24*NUM_SPRITES-1:0]   r_rgb;
   logic [NUM_SPRITES-1:0]      r_flip;

   logic [NUM_SPRITES-1:0]      w_opaque;
   logic [CW-1:0]               w_idx;
   logic [23:0]                 w_rgb;
   logic                        w_coll;

   // Stage 0: 11-bit window compares so sprites near the right/bottom edge never wrap.
   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
      logic [9:0] w_x, w_y;
      assign w_x = spr_x[10*i +: 10];
      assign w_y = spr_y[10*i +: 10];
      assign w_hit[i] = spr_en[i]
                      & ({1'b0, DrawX} >= {1'b0, w_x})
                      & ({1'b0, DrawX} <  ({1'b0, w_x} + 11'(SPRITE_W)))
                      & ({1'b0, DrawY} >= {1'b0, w_y})
                      & ({1'b0, DrawY} <  ({1'b0, w_y} + 11'(SPRITE_H)));
      assign rom_addr[ROM_AW*i +: ROM_AW] = w_hit[i]
                      ? spr_base[ROM_AW*i +: ROM_AW] + ROM_AW'(DrawY - w_y)
                      : '0;
      assign w_col[i] = CW'(DrawX - w_x);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_hit  <= '0;
         r_bg_r <= '0;
         r_bg_g <= '0;
         r_bg_b <= '0;
         r_text <= 1'b0;
         r_v1   <= 1'b0;
         r_rgb  <= '0;
         r_flip <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) r_col[i] <= '0;
      end else begin
         r_hit  <= w_hit & {NUM_SPRITES{pix_valid}};
         r_bg_r <= bg_r;
         r_bg_g <= bg_g;
         r_bg_b <= bg_b;
         r_text <= draw_text & text_pixel;
         r_v1   <= pix_valid;
         r_rgb  <= spr_rgb;
         r_flip <= spr_flip;
         for (int i = 0; i < NUM_SPRITES; i++) r_col[i] <= w_col[i];
      end
   end

   // Stage 1: ROM row has arrived; pick the mirrored or direct column bit.
   always_comb begin
      w_opaque = '0;
      w_idx    = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_idx       = r_flip[i] ? CW'(SPRITE_W - 1) - r_col[i] : r_col[i];
         w_opaque[i] = r_hit[i] & rom_data[i*SPRITE_W + int'(w_idx)];
      end
   end

   always_comb begin
      w_rgb = {r_bg_r, r_bg_g, r_bg_b};
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_opaque[i]) w_rgb = r_rgb[24*i +: 24];
      end
      if (r_text) w_rgb = 24'hFF_FFFF;
   end

   // Two or more opaque bits set <=> clearing the lowest one leaves something.
   assign w_coll = r_v1 & ((w_opaque & (w_opaque - NUM_SPRITES'(1))) != '0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         out_valid      <= 1'b0;
         VGA_R          <= '0;
         VGA_G          <= '0;
         VGA_B          <= '0;
         collision      <= '0;
         collision_last <= '0;
      end else begin
         out_valid <= r_v1;
         {VGA_R, VGA_G, VGA_B} <= r_v1 ? w_rgb : 24'h0;
         if (frame_start) begin
            collision_last <= collision;
            collision      <= w_coll ? w_opaque : '0;
         end else if (w_coll) begin
            collision <= collision | w_opaque;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
// tb_sprite_compositor : directed self-checking bench for sprite_compositor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

   localparam int N  = 6;
   localparam int W  = 32;
   localparam int AW = 7;

   logic              Clk, Reset, pix_valid, frame_start;
   logic [9:0]        DrawX, DrawY;
   logic [10*N-1:0]   spr_x, spr_y;
   logic [AW*N-1:0]   spr_base;
   logic [24*N-1:0]   spr_rgb;
   logic [N-1:0]      spr_en, spr_flip;
   logic [7:0]        bg_r, bg_g, bg_b;
   logic              draw_text, text_pixel;
   logic [AW*N-1:0]   rom_addr;
   logic [W*N-1:0]    rom_data;
   logic [7:0]        VGA_R, VGA_G, VGA_B;
   logic              out_valid;
   logic [N-1:0]      collision, collision_last;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [128];

   sprite_compositor #(.NUM_SPRITES(N), .SPRITE_W(W), .SPRITE_H(32), .ROM_AW(AW)) dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
      .spr_rgb(spr_rgb), .spr_en(spr_en), .spr_flip(spr_flip),
      .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .draw_text(draw_text), .text_pixel(text_pixel),
      .rom_addr(rom_addr), .rom_data(rom_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .out_valid(out_valid), .collision(collision), .collision_last(collision_last)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous ROM: one read port per sprite, data one cycle after address.
   always @(posedge Clk) begin
      for (int i = 0; i < N; i++) rom_data[i*W +: W] <= mem[rom_addr[i*AW +: AW]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pixel(input logic [9:0] x, input logic [9:0] y);
      DrawX = x;
      DrawY = y;
      pix_valid = 1'b1;
      #1;
   endtask

   task automatic finish_pix();
      tick();
      pix_valid = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] vga();
      return {8'h00, VGA_R, VGA_G, VGA_B};
   endfunction

   initial begin
      for (int a = 0; a < 128; a++) mem[a] = 32'h0;
      mem[64] = 32'h0000_0001;
      mem[74] = 32'h0000_0000;
      mem[0]  = 32'h0000_0400;
      mem[75] = 32'h0000_0002;
      mem[1]  = 32'h0000_0800;
      mem[32] = 32'hFFFF_FFFF;
      rom_data = '0;

      Reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
      DrawX = '0; DrawY = '0;
      spr_x = '0; spr_y = '0; spr_base = '0; spr_rgb = '0;
      spr_en = '0; spr_flip = '0;
      bg_r = 8'h0A; bg_g = 8'h14; bg_b = 8'h1E;
      draw_text = 1'b0; text_pixel = 1'b0;

      spr_x[0 +: 10] = 10'd100; spr_y[0 +: 10] = 10'd100; spr_base[0 +: AW] = 7'd64;
      spr_rgb[0 +: 24] = 24'hFF0000;
      spr_x[10 +: 10] = 10'd90; spr_y[10 +: 10] = 10'd110; spr_base[AW +: AW] = 7'd0;
      spr_rgb[24 +: 24] = 24'h00FF00;
      spr_x[20 +: 10] = 10'd620; spr_y[20 +: 10] = 10'd0; spr_base[2*AW +: AW] = 7'd32;
      spr_rgb[48 +: 24] = 24'h0000FF;
      spr_base[3*AW +: AW] = 7'd5; spr_rgb[72 +: 24] = 24'h123456;
      spr_en = 6'b000111;

      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_vga", vga(), 32'h0);
      chk("rst_collision", 32'(collision), 32'd0);
      chk("rst_collision_last", 32'(collision_last), 32'd0);
      Reset = 1'b0;
      tick();

      pixel(10'd100, 10'd100);
      chk("basic_rom_addr0", 32'(rom_addr[0 +: AW]), 32'd64);
      chk("basic_rom_addr1", 32'(rom_addr[AW +: AW]), 32'd0);
      tick();
      pix_valid = 1'b0;
      chk("basic_latency1", 32'(out_valid), 32'd0);
      tick();
      chk("basic_out_valid", 32'(out_valid), 32'd1);
      chk("basic_vga", vga(), 32'hFF0000);
      tick();
      chk("basic_out_valid_drop", 32'(out_valid), 32'd0);
      chk("basic_vga_zero", vga(), 32'h0);

      spr_flip = 6'b000001;
      pixel(10'd131, 10'd100);
      chk("flip_rom_addr0", 32'(rom_addr[0 +: AW]), 32'd64);
      finish_pix();
      chk("flip_right_edge", vga(), 32'hFF0000);
      pixel(10'd100, 10'd100);
      finish_pix();
      chk("flip_left_edge_bg", vga(), 32'h0A141E);
      spr_flip = 6'b000000;

      pixel(10'd100, 10'd110);
      chk("ovl_rom_addr0", 32'(rom_addr[0 +: AW]), 32'd74);
      chk("ovl_rom_addr1", 32'(rom_addr[AW +: AW]), 32'd0);
      finish_pix();
      chk("ovl_fallthrough", vga(), 32'h00FF00);
      chk("ovl_no_collision", 32'(collision), 32'd0);

      pixel(10'd101, 10'd111);
      chk("both_rom_addr0", 32'(rom_addr[0 +: AW]), 32'd75);
      chk("both_rom_addr1", 32'(rom_addr[AW +: AW]), 32'd1);
      finish_pix();
      chk("both_priority", vga(), 32'hFF0000);
      chk("both_collision", 32'(collision), 32'h03);

      draw_text = 1'b1; text_pixel = 1'b1;
      pixel(10'd101, 10'd111);
      finish_pix();
      chk("text_white", vga(), 32'hFFFFFF);
      draw_text = 1'b0; text_pixel = 1'b0;

      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_collision_last", 32'(collision_last), 32'h03);
      chk("fs_collision_clear", 32'(collision), 32'd0);

      // frame_start on the same edge as a stage-1 collision
      pixel(10'd101, 10'd111);
      tick();
      pix_valid = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_set_wins", 32'(collision), 32'h03);
      chk("fs_set_excluded", 32'(collision_last), 32'd0);

      pixel(10'd5, 10'd0);
      chk("wrap_rom_addr2", 32'(rom_addr[2*AW +: AW]), 32'd0);
      finish_pix();
      chk("wrap_no_hit", vga(), 32'h0A141E);
      pixel(10'd651, 10'd0);
      chk("edge_rom_addr2", 32'(rom_addr[2*AW +: AW]), 32'd32);
      finish_pix();
      chk("edge_last_col", vga(), 32'h0000FF);
      pixel(10'd652, 10'd0);
      chk("edge_past_rom_addr2", 32'(rom_addr[2*AW +: AW]), 32'd0);
      finish_pix();
      chk("edge_past_bg", vga(), 32'h0A141E);

      pixel(10'd0, 10'd0);
      chk("dis_rom_addr3", 32'(rom_addr[3*AW +: AW]), 32'd0);
      finish_pix();
      chk("dis_bg", vga(), 32'h0A141E);
      chk("dis_collision_kept", 32'(collision), 32'h03);

      pixel(10'd100, 10'd100);
      tick();
      pix_valid = 1'b0;
      tick();
      chk("tog_v1", 32'(out_valid), 32'd1);
      chk("tog_a", vga(), 32'hFF0000);
      pixel(10'd200, 10'd200);
      tick();
      pix_valid = 1'b0;
      chk("tog_v0", 32'(out_valid), 32'd0);
      chk("tog_gap", vga(), 32'h0);
      tick();
      chk("tog_v1b", 32'(out_valid), 32'd1);
      chk("tog_b", vga(), 32'h0A141E);

      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pixel(10'd101, 10'd111);
      tick(); tick(); tick();
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_collision", 32'(collision), 32'h03);
      chk("burst_collision_last", 32'(collision_last), 32'h03);
      #2 Reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_vga", vga(), 32'h0);
      chk("arst_collision", 32'(collision), 32'd0);
      chk("arst_collision_last", 32'(collision_last), 32'd0);
      tick();
      Reset = 1'b0;
      pix_valid = 1'b0;
      tick();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      pixel(10'd100, 10'd100);
      tick();
      pix_valid = 1'b0;
      chk("post_rst_lat1", 32'(out_valid), 32'd0);
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_vga", vga(), 32'hFF0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
